prog_sequencer: RTL
===================

// Module: prog_sequencer
// PURPOSE
//  Program-flow front end of the core, upstream of instruction ROM and datapath (rf1/dm1).
//  After reset release it launches program 1, 2 and 3 back to back, each from its own start address.
//  It generates the PC every cycle and applies branches and stalls from the datapath.
//  It asserts done once the last program halts; done is the signal the master bench waits on.
// PARAMETERS
//  PC_W     10        PC / instruction-address width
//  NPROG    3         programs run in succession (1..4)
//  START0   10'd0     start address, program 1
//  START1   10'd256   start address, program 2
//  START2   10'd512   start address, program 3
//  CT_W     16        per-program cycle-counter width
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      asynchronous, ACTIVE-LOW (reset==0 clears all state)
//  stall          in   1      datapath hold: PC and state frozen this cycle
//  halt           in   1      decoded halt instruction at current pc
//  br_take        in   1      branch taken this cycle
//  br_rel         in   1      1: pc+sext(br_off); 0: absolute br_tgt
//  br_off         in   8      signed relative offset
//  br_tgt         in   PC_W   absolute branch target
//  pc             out  PC_W   instruction address to ROM
//  prog_id        out  2      current program index (0..NPROG-1)
//  prog_start     out  1      1-cycle pulse at each launch; core clears flags/temps
//  run            out  1      core enable (1 in RUN only)
//  cycle_ct       out  CT_W   cycles spent in current program, saturating
//  overrun        out  1      sticky: sequential PC fetch wrapped past max address
//  done           out  1      all programs finished; held until reset
// BEHAVIOUR
//  Reset (async assert): state=LAUNCH, pc=START0, prog_id=0, cycle_ct=0.
//   prog_start=0, run=0, overrun=0, done=0.
//  FSM: LAUNCH -> RUN -> (LAUNCH | DONE); DONE is terminal.
//  LAUNCH (exactly 1 cycle): prog_start=1, pc=START[prog_id], cycle_ct cleared; next=RUN.
//   Inputs in LAUNCH are ignored.
//  RUN, priority per rising edge:
//   1. stall=1: hold pc/state, cycle_ct still counts; halt/br ignored.
//   2. halt=1: prog_id==NPROG-1 -> DONE. Else prog_id+1, pc=START[prog_id+1], ->LAUNCH.
//      halt beats a same-cycle br_take.
//   3. br_take=1: pc = br_rel ? pc+{{(PC_W-8){off[7]}},off} : br_tgt, mod 2^PC_W (wrap allowed).
//   4. else pc=pc+1; if pc=={PC_W{1}}: overrun=1, ->DONE (no wrap to 0).
//  cycle_ct: +1 each RUN cycle, saturates at all-ones, cleared in LAUNCH.
//   It holds its final value in DONE so the bench can read it.
//  DONE: done=1, run=0, pc/prog_id/cycle_ct frozen; all inputs ignored until reset.
//  Latency: pc for the first instruction of program 1 appears 1 cycle after reset rises.
//   Each program switch costs exactly 1 bubble cycle (LAUNCH).
//  Reset mid-program: async clear to reset state; the whole 3-program series restarts from START0.
//  All outputs are registered. No combinational input->output paths.
// STRUCTURE
//  seq_pkg: typedef enum logic[1:0] {S_LAUNCH,S_RUN,S_DONE} seq_state_t.
//   Also holds the PC_W default and the start-address table as localparam array START[NPROG].
//  Single module; no sub-module. Saturating counter inline (too small to split out).
// TESTING
//  Release reset, halt at pc 3, 258, 515 -> pc 0,1,2,3 | 256..258 | 512..515.
//   prog_start pulses 3x; done=1 one cycle after the 3rd halt.
//  RUN at pc=5: br_rel=1, br_off=8'hFD -> next pc=2.
//   Then br_rel=0, br_tgt=10'd40 -> pc=40.
//  Same cycle halt=1 and br_take=1 (tgt 99) -> launch next program; pc=START1, not 99.
//  stall=1 for 4 cycles with halt=1 -> pc, prog_id unchanged, cycle_ct +4.
//   Halt takes effect on the first unstalled edge.
//  Program 3 with no halt, sequential to pc=1023 -> overrun=1, done=1, pc frozen at 1023.
//  Pull reset low mid-program 2, release -> outputs at reset values immediately.
//   Full series reruns from pc=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer.
//  seq_state_t : LAUNCH (one bubble per program launch), RUN, DONE (terminal)
//  PC_W_DEF    : default PC / instruction-address width
//  NPROG_MAX   : largest supported program count
//  START       : default start-address table, one entry per program slot
package seq_pkg;

  localparam int unsigned PC_W_DEF  = 10;
  localparam int unsigned NPROG_MAX = 4;

  typedef enum logic [1:0] {
    S_LAUNCH = 2'd0,
    S_RUN    = 2'd1,
    S_DONE   = 2'd2
  } seq_state_t;

  localparam logic [PC_W_DEF-1:0] START [NPROG_MAX] = '{10'd0, 10'd256, 10'd512, 10'd768};

endpackage

// File: rtl/prog_sequencer.sv
// Program-flow front end: launches NPROG programs back to back, generates
// the PC every cycle and applies datapath stalls and branches.
// Ports:
//  clk        in   rising-edge clock
//  reset      in   asynchronous, active-low
//  stall      in   hold pc/state this cycle (cycle_ct still counts)
//  halt       in   halt decoded at current pc
//  br_take    in   branch taken this cycle
//  br_rel     in   1: pc + sext(br_off), 0: absolute br_tgt
//  br_off     in   signed 8-bit relative offset
//  br_tgt     in   absolute branch target
//  pc         out  instruction address
//  prog_id    out  current program index
//  prog_start out  one-cycle pulse at each launch
//  run        out  core enable, high only in RUN
//  cycle_ct   out  saturating cycles spent in current program
//  overrun    out  sticky: sequential fetch ran off the top of the address space
//  done       out  all programs finished, held until reset
import seq_pkg::*;

module prog_sequencer #(
  parameter int unsigned       PC_W   = PC_W_DEF,
  parameter int unsigned       NPROG  = 3,
  parameter logic [PC_W-1:0]   START0 = PC_W'(START[0]),
  parameter logic [PC_W-1:0]   START1 = PC_W'(START[1]),
  parameter logic [PC_W-1:0]   START2 = PC_W'(START[2]),
  parameter logic [PC_W-1:0]   START3 = PC_W'(START[3]),
  parameter int unsigned       CT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt,
  input  logic            br_take,
  input  logic            br_rel,
  input  logic [7:0]      br_off,
  input  logic [PC_W-1:0] br_tgt,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      prog_id,
  output logic            prog_start,
  output logic            run,
  output logic [CT_W-1:0] cycle_ct,
  output logic            overrun,
  output logic            done
);

  seq_state_t      state;
  logic [PC_W-1:0] start_tbl [NPROG_MAX];
  logic [PC_W-1:0] br_dest;
  logic [1:0]      next_id;

  always_comb begin
    start_tbl[0] = START0;
    start_tbl[1] = START1;
    start_tbl[2] = START2;
    start_tbl[3] = START3;
  end

  always_comb begin
    next_id = prog_id + 2'd1;
    br_dest = br_rel ? (pc + {{(PC_W-8){br_off[7]}}, br_off}) : br_tgt;
  end

  // run/done are pure decodes of the state register, so they stay glitch-free
  // and carry no path from the inputs.
  always_comb begin
    run  = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_LAUNCH;
      pc         <= START0;
      prog_id    <= '0;
      cycle_ct   <= '0;
      prog_start <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        S_LAUNCH: begin
          prog_start <= 1'b1;
          pc         <= start_tbl[prog_id];
          cycle_ct   <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          prog_start <= 1'b0;
          if (cycle_ct != '1) cycle_ct <= cycle_ct + CT_W'(1);
          if (stall) begin
            // frozen; halt and branch wait for the first unstalled edge
          end else if (halt) begin
            if (prog_id == 2'(NPROG - 1)) begin
              state <= S_DONE;
            end else begin
              prog_id <= next_id;
              pc      <= start_tbl[next_id];
              state   <= S_LAUNCH;
            end
          end else if (br_take) begin
            pc <= br_dest;
          end else if (pc == '1) begin
            // no wrap to 0: stop the series with pc parked at the top address
            overrun <= 1'b1;
            state   <= S_DONE;
          end else begin
            pc <= pc + PC_W'(1);
          end
        end
        S_DONE: begin
          prog_start <= 1'b0;
        end
        default: begin
          prog_start <= 1'b0;
          state      <= S_DONE;
        end
      endcase
    end
  end

endmodule
